// File: rtl/contador_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | contador_pkg                                                       |
// | Shared types and constants for the tempo configuration block:      |
// | editor FSM states, field limits, key slot indices and a wrapping   |
// | up/down step helper.                                               |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package contador_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SET_MIN = 2'd1,
      ST_SET_SEC = 2'd2,
      ST_COMMIT  = 2'd3
   } state_t;

   localparam int MAX_MIN     = 99;
   localparam int MAX_SEC     = 59;
   localparam int SEC_PER_MIN = 60;

   // Slot of each push-button in the internal key vector
   localparam int NUM_KEYS  = 6;
   localparam int KEY_MODE  = 0;
   localparam int KEY_UP    = 1;
   localparam int KEY_DOWN  = 2;
   localparam int KEY_OK    = 3;
   localparam int KEY_PAUSE = 4;
   localparam int KEY_ZERO  = 5;

   // One step up or down over 0..max_v, wrapping at both ends
   function automatic logic [6:0] wrap_step(input logic [6:0] v,
                                            input logic [6:0] max_v,
                                            input logic       up);
      logic [6:0] r;
      if (up) r = (v == max_v) ? 7'd0 : v + 7'd1;
      else    r = (v == 7'd0)  ? max_v : v - 7'd1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tempo_config_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tempo_config_if                                                    |
// | Key/switch inputs and configuration outputs of tempo_config.       |
// |   key_*  : raw active-low push-buttons                             |
// |   sw_sel : raw mode switch (0 stopwatch, 1 countdown)              |
// |   tempo  : configured seconds, cfg: edit active, salve: commit     |
// |   sel    : synced sw_sel, pause: freeze level, reseta: restart tgl |
// | master drives the keys; slave is the configuration block.          |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface tempo_config_if;
   logic        key_mode;
   logic        key_up;
   logic        key_down;
   logic        key_ok;
   logic        key_pause;
   logic        key_zero;
   logic        sw_sel;
   logic [15:0] tempo;
   logic        cfg;
   logic        salve;
   logic        sel;
   logic        pause;
   logic        reseta;

   modport master (
      output key_mode, key_up, key_down, key_ok, key_pause, key_zero, sw_sel,
      input  tempo, cfg, salve, sel, pause, reseta
   );

   modport slave (
      input  key_mode, key_up, key_down, key_ok, key_pause, key_zero, sw_sel,
      output tempo, cfg, salve, sel, pause, reseta
   );
endinterface
`default_nettype wire

// File: rtl/debounce_tecla.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | debounce_tecla                                                     |
// | 2-FF synchronizer, counter debouncer and press-pulse generator for |
// | one active-low push-button.                                        |
// |   clk, reseta_n : clock, async active-low reset                    |
// |   key_raw       : raw button level                                 |
// |   press         : one-cycle pulse on accepted 1->0 transition      |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module debounce_tecla #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reseta_n,
   input  logic key_raw,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic [CW-1:0] r_cnt;
   logic          r_press;

   always_ff @(posedge clk or negedge reseta_n) begin
      if (!reseta_n) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_cnt    <= '0;
         r_press  <= 1'b0;
      end else begin
         r_sync1 <= key_raw;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_stable) begin
            // any agreeing sample restarts the stability window
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            // DEB_CYCLES-th consecutive differing sample: accept level
            r_stable <= r_sync2;
            r_cnt    <= '0;
            r_press  <= ~r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/tempo_config.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tempo_config                                                       |
// | Push-button editor for a MM:SS time value with commit strobe,      |
// | pause level, restart toggle and synchronized mode select.          |
// |   clk      : 50 MHz system clock                                   |
// |   reseta_n : async active-low reset                                |
// |   bus      : tempo_config_if.slave (keys in, configuration out)    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tempo_config
   import contador_pkg::*;
#(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               reseta_n,
   tempo_config_if.slave      bus
);

   logic [NUM_KEYS-1:0] w_key_raw;
   logic [NUM_KEYS-1:0] w_ev;

   assign w_key_raw[KEY_MODE]  = bus.key_mode;
   assign w_key_raw[KEY_UP]    = bus.key_up;
   assign w_key_raw[KEY_DOWN]  = bus.key_down;
   assign w_key_raw[KEY_OK]    = bus.key_ok;
   assign w_key_raw[KEY_PAUSE] = bus.key_pause;
   assign w_key_raw[KEY_ZERO]  = bus.key_zero;

   generate
      for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
         debounce_tecla #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk      (clk),
            .reseta_n (reseta_n),
            .key_raw  (w_key_raw[k]),
            .press    (w_ev[k])
         );
      end
   endgenerate

   // sw_sel is a level switch: synchronize only
   logic r_sw_sync1;
   logic r_sw_sync2;

   state_t      r_state;
   logic [6:0]  r_min;
   logic [5:0]  r_sec;
   logic        r_cfg;
   logic        r_salve;
   logic        r_sel;
   logic        r_pause;
   logic        r_reseta;
   logic [15:0] r_tempo;
   logic [12:0] w_total;

   // up and down together cancel each other
   logic w_step_en;
   assign w_step_en = w_ev[KEY_UP] ^ w_ev[KEY_DOWN];

   always_ff @(posedge clk or negedge reseta_n) begin
      if (!reseta_n) begin
         r_sw_sync1 <= 1'b0;
         r_sw_sync2 <= 1'b0;
         r_state    <= ST_IDLE;
         r_min      <= '0;
         r_sec      <= '0;
         r_cfg      <= 1'b0;
         r_salve    <= 1'b0;
         r_sel      <= 1'b0;
         r_pause    <= 1'b0;
         r_reseta   <= 1'b0;
      end else begin
         r_sw_sync1 <= bus.sw_sel;
         r_sw_sync2 <= r_sw_sync1;
         r_salve    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_sel <= r_sw_sync2;
               if (w_ev[KEY_MODE]) begin
                  r_state <= ST_SET_MIN;
                  r_cfg   <= 1'b1;
                  r_pause <= 1'b0;
               end else begin
                  if (w_ev[KEY_PAUSE]) r_pause  <= ~r_pause;
                  if (w_ev[KEY_ZERO])  r_reseta <= ~r_reseta;
               end
            end
            ST_SET_MIN, ST_SET_SEC: begin
               if (w_ev[KEY_OK]) begin
                  r_state <= ST_COMMIT;
                  r_cfg   <= 1'b0;
                  r_salve <= 1'b1;
                  r_pause <= 1'b0;
               end else if (w_ev[KEY_MODE]) begin
                  r_state <= (r_state == ST_SET_MIN) ? ST_SET_SEC : ST_SET_MIN;
               end else if (w_step_en) begin
                  if (r_state == ST_SET_MIN)
                     r_min <= wrap_step(r_min, 7'(MAX_MIN), w_ev[KEY_UP]);
                  else
                     r_sec <= 6'(wrap_step({1'b0, r_sec}, 7'(MAX_SEC), w_ev[KEY_UP]));
               end
            end
            ST_COMMIT: begin
               r_state <= ST_IDLE;
               r_cfg   <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cfg   <= 1'b0;
            end
         endcase
      end
   end

   assign w_total = 13'(r_min) * 13'(SEC_PER_MIN) + 13'(r_sec);

   always_ff @(posedge clk or negedge reseta_n) begin
      if (!reseta_n) r_tempo <= '0;
      else           r_tempo <= {3'b000, w_total};
   end

   assign bus.tempo  = r_tempo;
   assign bus.cfg    = r_cfg;
   assign bus.salve  = r_salve;
   assign bus.sel    = r_sel;
   assign bus.pause  = r_pause;
   assign bus.reseta = r_reseta;

endmodule
`default_nettype wire

// File: doc/tempo_config.md
TEMPO_CONFIG -- requirements
Module: tempo_config

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, consecutive stable clk cycles required to accept a key level change (20 ms at 50 MHz).
REQ-002 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-003 reseta_n  input  1  asynchronous, active-low reset.
REQ-004 key_mode, key_up, key_down, key_ok, key_pause, key_zero  input  1 each  raw push-buttons, active-low, asynchronous to clk.
REQ-005 sw_sel  input  1  raw mode switch: 0 = stopwatch, 1 = countdown timer.
REQ-006 tempo  output  16  configured time in seconds, unsigned, range 0..5999.
REQ-007 cfg  output  1  high while in an edit state.
REQ-008 salve  output  1  one-cycle commit strobe.
REQ-009 sel  output  1  registered, synchronized copy of sw_sel.
REQ-010 pause  output  1  level: 1 = counter display frozen.
REQ-011 reseta  output  1  toggle line; every level change requests a counter restart.

Function
REQ-012 Each key and sw_sel SHALL pass through a 2-FF synchronizer; each key SHALL then be debounced: stable level changes only after DEB_CYCLES consecutive cycles of differing synchronized input.
REQ-013 A press event SHALL be a single-cycle pulse on the debounced 1->0 transition; releases generate no event.
REQ-014 FSM states: IDLE, SET_MIN, SET_SEC, COMMIT.
REQ-015 IDLE: cfg=0; key_mode -> SET_MIN; key_pause toggles pause; key_zero toggles reseta; sel samples the synchronized sw_sel every cycle.
REQ-016 SET_MIN: cfg=1; key_up increments minutes with 99->0 wrap; key_down decrements with 0->99 wrap; key_mode -> SET_SEC; key_ok -> COMMIT.
REQ-017 SET_SEC: cfg=1; key_up/key_down modify seconds over 0..59 with 59->0 and 0->59 wrap; key_mode -> SET_MIN; key_ok -> COMMIT.
REQ-018 COMMIT: exactly one cycle; cfg=0, salve=1, pause=0; unconditional return to IDLE.
REQ-019 salve SHALL be 0 in every state other than COMMIT.
REQ-020 Entering SET_MIN from IDLE SHALL clear pause in the same edge.
REQ-021 In SET_MIN/SET_SEC, key_pause and key_zero events SHALL be discarded; sel SHALL hold its value until IDLE is re-entered.
REQ-022 Same-cycle events priority: ok > mode > up > down; lower-priority events in that cycle are discarded.
REQ-023 up and down in the same cycle with no higher-priority event SHALL change nothing.
REQ-024 tempo SHALL equal minutes*60+seconds, registered, updated one cycle after a field change, live in all states; arithmetic in at least 13 bits, zero-extended to 16.
REQ-025 Minutes and seconds SHALL be retained across COMMIT and re-entry to edit states.

Reset
REQ-026 While reseta_n=0: state=IDLE, minutes=0, seconds=0, tempo=0, cfg=0, salve=0, sel=0, pause=0, reseta=0, debounced keys=1 (released), debounce counters=0, synchronizers=1 for keys, 0 for sw_sel.
REQ-027 Reset asserted mid-edit SHALL discard edits with no salve pulse; first event after release is evaluated from IDLE.
REQ-028 A key held low through reset release SHALL produce one press event after DEB_CYCLES cycles.

Structure
REQ-029 Shared package contador_pkg SHALL hold the FSM state enum, MAX_MIN=99, MAX_SEC=59, SEC_PER_MIN=60.
REQ-030 One sub-module, debounce_tecla (synchronizer + debounce + press pulse), SHALL be instantiated once per key; sw_sel uses synchronizer only.

Verification (DEB_CYCLES=4)
REQ-031 Bounce key_up 3 cycles low/high then hold low 10 cycles, in SET_MIN -> exactly one increment, minutes 0->1, tempo=60.
REQ-032 From reset: mode, down, mode, down, down, ok -> minutes=99, seconds=58, tempo=5998, salve high exactly one cycle, then cfg=0.
REQ-033 In IDLE press key_pause twice and key_zero once -> pause 0->1->0, reseta 0->1; in SET_SEC same presses -> no change.
REQ-034 key_ok and key_up pressed same cycle in SET_SEC -> COMMIT, seconds unchanged.
REQ-035 Assert reseta_n mid-SET_SEC with minutes=5 -> all outputs 0, state IDLE, no salve pulse.
REQ-036 Toggle sw_sel during SET_MIN -> sel unchanged until IDLE, then follows after synchronizer latency.
